// File: rtl/tsu_queue_reader.sv
// tsu_queue_reader: drains a tsu_queue timestamp FIFO into a 2-entry
// prefetch buffer and presents decoded entries on a valid/ready port.
//
// Ports:
//   q_rd_clk, q_rst_n        clock, synchronous active-low reset
//   q_rd_stat, q_rd_data     queue fill level and read data (data valid
//                            the cycle after q_rd_en)
//   q_rd_en                  single-cycle pop strobe to the queue
//   flush                    level; discard buffer and drain the queue
//   ts_valid, ts_ready       host handshake for the head entry
//   ts_msg, ts_seqid, ts_time  decoded head entry fields
//   rd_count, flush_count    wrapping delivered / discarded counters
//   busy                     read in flight or flush drain active
module tsu_queue_reader #(
    parameter int DEPTH_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               q_rd_clk,
    input  logic               q_rst_n,
    input  logic [DEPTH_W-1:0] q_rd_stat,
    input  logic [47:0]        q_rd_data,
    output logic               q_rd_en,
    input  logic               flush,
    input  logic               ts_ready,
    output logic               ts_valid,
    output logic [1:0]         ts_msg,
    output logic [15:0]        ts_seqid,
    output logic [29:0]        ts_time,
    output logic [CNT_W-1:0]   rd_count,
    output logic [CNT_W-1:0]   flush_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } state_t;

    state_t      state;
    // pend: a pop was issued last cycle; its data arrives this cycle.
    // It doubles as "q_rd_en was high in the previous cycle", which is
    // exactly when q_rd_stat is still stale.
    logic        pend;
    logic [47:0] slot [2];
    logic        head;
    logic [1:0]  occ;

    logic             issue;
    logic             cap;
    logic             drop;
    logic             fire;
    logic             tail;
    logic [1:0]       occ_nxt;
    logic [CNT_W-1:0] flush_add;
    logic [2:0]       room;

    always_comb begin
        room  = {1'b0, occ} + {2'b00, pend};
        issue = 1'b0;
        if (q_rst_n && (q_rd_stat != '0) && !pend) begin
            if (flush) begin
                issue = 1'b1;
            end else begin
                issue = (state != FLUSH) && (room < 3'd2);
            end
        end

        ts_valid = (occ != 2'd0) && !flush && (state != FLUSH);
        fire     = ts_valid && ts_ready;
        cap      = pend && !flush && (state != FLUSH);
        drop     = pend && (flush || (state == FLUSH));
        tail     = head ^ occ[0];

        occ_nxt = occ;
        if (flush) begin
            occ_nxt = 2'd0;
        end else begin
            unique case (1'b1)
                cap && !fire: occ_nxt = occ + 2'd1;
                fire && !cap: occ_nxt = occ - 2'd1;
                default:      occ_nxt = occ;
            endcase
        end

        // Entries cleared by flush plus any beat that lands during flush.
        flush_add = CNT_W'(flush ? occ : 2'd0) + CNT_W'(drop);
    end

    // The pop decision uses the live fill level so the strobe lands in
    // the same cycle the queue reports non-empty.
    assign q_rd_en  = issue;
    assign ts_msg   = slot[head][47:46];
    assign ts_seqid = slot[head][45:30];
    assign ts_time  = slot[head][29:0];
    assign busy     = (state != IDLE);

    always_ff @(posedge q_rd_clk) begin
        if (!q_rst_n) begin
            state       <= IDLE;
            pend        <= 1'b0;
            head        <= 1'b0;
            occ         <= 2'd0;
            rd_count    <= '0;
            flush_count <= '0;
            for (int i = 0; i < 2; i++) begin
                slot[i] <= '0;
            end
        end else begin
            pend        <= issue;
            occ         <= occ_nxt;
            flush_count <= flush_count + flush_add;
            if (cap) begin
                slot[tail] <= q_rd_data;
            end
            if (fire) begin
                head     <= ~head;
                rd_count <= rd_count + CNT_W'(1);
            end
            if (flush) begin
                state <= FLUSH;
            end else begin
                unique case (state)
                    IDLE:    if (issue) state <= FETCH;
                    FETCH:   if (pend) state <= IDLE;
                    FLUSH:   if (!pend) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tsu_queue_reader.sv
// tb_tsu_queue_reader: scoreboard bench for tsu_queue_reader with a
// behavioural tsu_queue model feeding q_rd_stat / q_rd_data.
module tb_tsu_queue_reader;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          q_rst_n;
    logic [DW-1:0] q_rd_stat;
    logic [47:0]   q_rd_data;
    logic          q_rd_en;
    logic          flush;
    logic          ts_ready;
    logic          ts_valid;
    logic [1:0]    ts_msg;
    logic [15:0]   ts_seqid;
    logic [29:0]   ts_time;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] flush_count;
    logic          busy;

    always #5 clk = ~clk;

    tsu_queue_reader #(.DEPTH_W(DW), .CNT_W(CW)) dut (
        .q_rd_clk   (clk),
        .q_rst_n    (q_rst_n),
        .q_rd_stat  (q_rd_stat),
        .q_rd_data  (q_rd_data),
        .q_rd_en    (q_rd_en),
        .flush      (flush),
        .ts_ready   (ts_ready),
        .ts_valid   (ts_valid),
        .ts_msg     (ts_msg),
        .ts_seqid   (ts_seqid),
        .ts_time    (ts_time),
        .rd_count   (rd_count),
        .flush_count(flush_count),
        .busy       (busy)
    );

    logic [47:0] qmem [$];
    logic [47:0] expq [$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_en = 1'b0;
    logic        qpop;
    logic [47:0] mon_e;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] mk(input int i);
        logic [1:0]  m;
        logic [15:0] s;
        logic [29:0] t;
        m = i[1:0];
        s = 16'h0100 + i[15:0];
        t = i[29:0] * 30'h1000 + 30'd7;
        return {m, s, t};
    endfunction

    // Queue model: pops on a sampled q_rd_en, read data and fill level
    // are registered and settle shortly after the edge.
    always @(posedge clk) begin
        qpop = q_rd_en;
        #2;
        if (qpop && qmem.size() > 0) q_rd_data = qmem.pop_front();
        q_rd_stat = DW'(qmem.size());
    end

    // Monitor: compare every accepted entry against the scoreboard.
    always @(negedge clk) begin
        if (q_rst_n) begin
            if (q_rd_en) check("no_b2b_pop", prev_en, 0);
            if (ts_valid && ts_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got %0h expected none",
                             {ts_msg, ts_seqid, ts_time});
                end else begin
                    mon_e = expq.pop_front();
                    check("entry", {ts_msg, ts_seqid, ts_time}, mon_e);
                end
            end
        end
        prev_en = q_rd_en;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] d, input bit keep);
        qmem.push_back(d);
        if (keep) expq.push_back(d);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (expq.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", expq.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n_en;
        int          n;
        logic [47:0] e;

        q_rst_n   = 1'b0;
        flush     = 1'b0;
        ts_ready  = 1'b0;
        q_rd_stat = '0;
        q_rd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", q_rd_en, 0);
        check("rst_valid", ts_valid, 0);
        check("rst_fields", {ts_msg, ts_seqid, ts_time}, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_flush_count", flush_count, 0);
        check("rst_busy", busy, 0);
        step;
        q_rst_n = 1'b1;

        // Single entry, N / N+1 / N+2 latency
        step;
        ts_ready = 1'b1;
        push(48'hC000_4000_0123, 1);
        @(negedge clk);
        check("single_en_n", q_rd_en, 1);
        @(negedge clk);
        check("single_en_n1", q_rd_en, 0);
        check("single_valid_n1", ts_valid, 0);
        check("single_busy_n1", busy, 1);
        @(negedge clk);
        check("single_valid_n2", ts_valid, 1);
        check("single_msg", ts_msg, 3);
        check("single_seqid", ts_seqid, 16'h0001);
        check("single_time", ts_time, 30'h123);
        @(negedge clk);
        check("single_rd_count", rd_count, 1);
        check("single_valid_n3", ts_valid, 0);
        check("single_busy_n3", busy, 0);

        // Burst under backpressure
        step;
        ts_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk(i), 1);
        n_en = 0;
        repeat (12) begin
            @(negedge clk);
            if (q_rd_en) n_en++;
        end
        e = mk(0);
        check("burst_pops", n_en, 2);
        check("burst_valid", ts_valid, 1);
        check("burst_stat", q_rd_stat, 3);
        check("burst_hold", ts_seqid, e[45:30]);
        step;
        ts_ready = 1'b1;
        drain(40);
        check("burst_rd_count", rd_count, 6);

        // Capture and consume in the same cycle
        step;
        ts_ready = 1'b0;
        push(mk(10), 1);
        push(mk(11), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q_rd_en && ts_valid) && n < 20);
        check("simul_sync", q_rd_en && ts_valid, 1);
        step;
        ts_ready = 1'b1;
        @(negedge clk);
        check("simul_pend", busy, 1);
        step;
        ts_ready = 1'b0;
        @(negedge clk);
        e = mk(11);
        check("simul_valid", ts_valid, 1);
        check("simul_head", ts_seqid, e[45:30]);
        check("simul_rd_count", rd_count, 7);
        step;
        ts_ready = 1'b1;
        drain(20);
        check("simul_rd_count2", rd_count, 8);

        // Flush: 2 buffered + 3 queued
        step;
        ts_ready = 1'b0;
        for (int i = 20; i < 25; i++) push(mk(i), 0);
        repeat (10) @(negedge clk);
        check("pre_flush_valid", ts_valid, 1);
        check("pre_flush_stat", q_rd_stat, 3);
        step;
        flush    = 1'b1;
        ts_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("flush_valid_low", ts_valid, 0);
        end
        check("flush_stat", q_rd_stat, 0);
        check("flush_count", flush_count, 5);
        step;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_hold", busy, 1);
        @(negedge clk);
        check("flush_busy_fall", busy, 0);
        check("flush_count_end", flush_count, 5);
        check("flush_rd_count", rd_count, 8);

        // Reset with a pop in flight
        step;
        push(mk(30), 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!q_rd_en && n < 10);
        check("rstmid_en", q_rd_en, 1);
        step;
        q_rst_n = 1'b0;
        step;
        @(negedge clk);
        check("rstmid_en0", q_rd_en, 0);
        check("rstmid_valid", ts_valid, 0);
        check("rstmid_fields", {ts_msg, ts_seqid, ts_time}, 0);
        check("rstmid_rd_count", rd_count, 0);
        check("rstmid_flush_count", flush_count, 0);
        check("rstmid_busy", busy, 0);
        step;
        q_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstmid_not_stored", ts_valid, 0);
        step;
        push(mk(31), 1);
        drain(20);
        check("rstmid_refetch", rd_count, 1);

        // Counter wrap
        for (int i = 0; i < 254; i++) begin
            step;
            push(mk(40 + i), 1);
            drain(20);
        end
        check("wrap_max", rd_count, 8'hFF);
        step;
        push(mk(500), 1);
        drain(20);
        check("wrap_zero", rd_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tsu_queue_reader.md
# tsu_queue_reader

Drains a tsu_queue timestamp FIFO through its q_rd_* port and presents each entry to the host side as decoded fields with a valid/ready handshake. It sits in the q_rd_clk domain, one instance per tsu_queue (RX and TX), between the queue and the register/CPU interface. It prefetches into a 2-entry output buffer, so the host sees back-to-back timestamps. It also provides a flush that discards all queued entries and counts them.

## Interface
- DEPTH_W, 8: width of q_rd_stat (queue fill level).
- CNT_W, 16: width of the read and flush counters.
- q_rd_clk  in  1  sole clock; the queue read clock.
- q_rst_n  in  1  reset, synchronous, active-low.
- q_rd_stat  in  DEPTH_W  queue fill level; registered by the queue and updated the cycle after a pop.
- q_rd_data  in  48  queue read data; valid the cycle after q_rd_en.
- q_rd_en  out  1  single-cycle pop strobe to the queue.
- flush  in  1  level; while high, discard the buffer and drain the queue.
- ts_ready  in  1  host accepts the current entry.
- ts_valid  out  1  entry present on ts_* outputs.
- ts_msg  out  2  message class, q_rd_data[47:46].
- ts_seqid  out  16  PTP sequenceId, q_rd_data[45:30].
- ts_time  out  30  RTC timestamp, q_rd_data[29:0].
- rd_count  out  CNT_W  entries delivered to the host; wraps.
- flush_count  out  CNT_W  entries discarded by flush; wraps.
- busy  out  1  a read is in flight or flush drain is active.

## Operation
- Buffer: 2-entry FIFO (slot pointer plus occupancy 0..2). The ts_* outputs show the head entry.
- Issue rule: assert q_rd_en when all of the following hold:
  - q_rd_stat != 0;
  - occupancy + inflight < 2;
  - q_rd_en was low in the previous cycle (q_rd_stat is stale for one cycle after a pop);
  - no pop is in flight.
  - Result: at most one pop every 2 cycles.
- Capture: in the cycle after q_rd_en, q_rd_data is written into the buffer tail and occupancy increments.
- Handshake: the head is consumed on a cycle with ts_valid && ts_ready. On consume, rd_count increments by 1, modulo 2^CNT_W.
- Simultaneous capture and consume: occupancy is unchanged, and the head advances to the next slot.
- FSM states IDLE, FETCH, FLUSH:
  - IDLE -> FETCH: issue rule true.
  - FETCH -> IDLE: data captured.
  - Any state -> FLUSH: flush high.
  - FLUSH -> IDLE: flush low, no pop in flight, and the cycle's data (if any) has been discarded.
- FLUSH behaviour:
  - Occupancy is cleared immediately; each cleared valid entry adds 1 to flush_count.
  - ts_valid is forced low.
  - q_rd_en follows the issue rule, ignoring occupancy.
  - Each data beat returned adds 1 to flush_count and is not stored.
  - rd_count does not change.
- If flush drops while a pop is in flight, that beat is still discarded and counted.
- busy = (state != IDLE).

## Timing
- Reset, synchronous on q_rd_clk while q_rst_n = 0: q_rd_en=0, ts_valid=0, ts_msg/ts_seqid/ts_time=0, rd_count=0, flush_count=0, busy=0, occupancy=0, state IDLE. A read in flight at reset is abandoned and its data is ignored.
- Latency from the queue going non-empty to ts_valid, with the buffer empty:
  - cycle N: q_rd_stat!=0 sampled, q_rd_en=1.
  - cycle N+1: data captured.
  - cycle N+2: ts_valid=1.
- Sustained throughput: 1 entry per 2 cycles, limited by the queue status latency.
- ts_valid stays high and ts_* stay stable until accepted. ts_ready is ignored while ts_valid=0.
- Counter wrap: 0xFFFF + 1 -> 0x0000, with no sticky flag.
- Buffer full (occupancy 2): no q_rd_en, even when q_rd_stat != 0.
- Queue empty: no q_rd_en.

## Test plan
- Single entry: queue holds 1 entry, q_rd_data=0xC000_4000_0123, ts_ready=1 -> ts_valid at N+2 with ts_msg=3, ts_seqid=0x0001, ts_time=0x0000123; rd_count=1.
- Burst with backpressure: 5 entries queued, ts_ready=0 -> exactly 2 q_rd_en pulses, occupancy 2. Then ts_ready=1 -> 5 entries delivered in order, q_rd_en never in consecutive cycles, rd_count=5.
- Simultaneous: buffer at 1 entry, capture and consume in the same cycle -> occupancy stays 1, no entry lost or duplicated.
- Flush: 2 buffered + 3 queued, flush held 10 cycles -> ts_valid low throughout, q_rd_stat reaches 0, flush_count=5, rd_count unchanged, busy falls after flush drops.
- Reset mid-read: q_rst_n low in the cycle after q_rd_en -> all outputs 0 and the returned beat not stored. After release, the next entry is fetched normally.
- Wrap: preload rd_count to 0xFFFF via 65535 deliveries, then deliver 1 more -> rd_count=0x0000.
